imem_boot_loader: RTL and testbench
===================================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameters SHALL be ADDR_W (default 10, instruction memory address width) and DATA_W (default 18, instruction word width); DEPTH = 2**ADDR_W.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load_start  input  1  one-cycle request to begin or restart a program load.
REQ-005 load_len  input  ADDR_W+1  number of data words to load; sampled only in the cycle load_start=1.
REQ-006 in_valid  input  1  source has a word on in_data.
REQ-007 in_data  input  DATA_W  program word, or checksum trailer when CHECK is active.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 imem_we  output  1  instruction memory write enable.
REQ-010 imem_addr  output  ADDR_W  instruction memory write address.
REQ-011 imem_wdata  output  DATA_W  instruction memory write data.
REQ-012 cpu_reset  output  1  holds the CPU in reset while high.
REQ-013 busy  output  1  high in LOAD or CHECK.
REQ-014 done  output  1  one-cycle pulse in the first RUN cycle of each completed load.
REQ-015 err  output  1  checksum mismatch flag.

Function
REQ-016 States SHALL be IDLE, LOAD, CHECK, ERROR and RUN.
REQ-017 IDLE: cpu_reset=1, in_ready=0; load_start moves to LOAD.
REQ-018 On load_start, the count SHALL clear to 0, the running XOR SHALL clear to 0, and the length SHALL latch as min(load_len, DEPTH).
REQ-019 A latched length of 0 SHALL go directly to RUN (or to CHECK with LOADER_CHECKSUM_EN) on the next edge.
REQ-020 in_ready SHALL be high only in LOAD or CHECK and only while load_start=0.
REQ-021 A word is accepted only when in_valid=1 and in_ready=1; in_valid=0 stalls with no state change.
REQ-022 In LOAD, accepted words SHALL write combinationally (zero latency): imem_we=1, imem_addr=count, imem_wdata=in_data; imem_we=0 in every other case.
REQ-023 After each accepted word, count SHALL increment by 1 and the running XOR SHALL update with in_data.
REQ-024 When the accepted word has count = length-1, the next state SHALL be RUN (or CHECK with LOADER_CHECKSUM_EN).
REQ-025 count never exceeds DEPTH-1 when used as an address; it does not wrap.
REQ-026 RUN: cpu_reset=0 from its first cycle; done=1 for that cycle only; in_ready=0.
REQ-027 load_start in any state SHALL restart into LOAD and reassert cpu_reset the next cycle.
REQ-028 load_start wins over a simultaneous handshake: the word is not accepted.
REQ-029 Instruction memory contents already written are never cleared by the loader.

Reset
REQ-030 Synchronous reset SHALL force state=IDLE, cpu_reset=1, count=0, XOR=0, latched length=0, and in_ready, imem_we, busy, done, err = 0.
REQ-031 Reset during LOAD or CHECK SHALL abort the load with no further writes; reset has priority over load_start.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: after the last data word the state SHALL go to CHECK and accept exactly one trailer word (no memory write).
REQ-033 If the trailer equals the running XOR, the state SHALL go to RUN; otherwise it SHALL go to ERROR (err=1, cpu_reset=1, in_ready=0) until load_start or reset.
REQ-034 err SHALL clear on load_start.
REQ-035 Macro LOADER_CHECKSUM_EN undefined: CHECK and ERROR do not exist, err is tied to 0, and the last data word goes directly to RUN.

Verification
REQ-036 Load: load_len=7, words 08004, 24000, 20400, 04840, 24801, 0cc81, 24c00 with in_valid held high -> 7 writes to addresses 0..6 on consecutive cycles, done pulses once, and cpu_reset falls in the cycle after the 7th write.
REQ-037 Backpressure: load_len=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 writes to addresses 0,1,2 with no duplicates; busy stays high until RUN.
REQ-038 Restart: load_start during RUN, then again after 2 of 5 words -> cpu_reset reasserts, and the next word writes address 0.
REQ-039 Edge cases: load_len=0 -> no writes and RUN two cycles after load_start; load_len=1500 -> clamps to 1024 with last write at address 1023.
REQ-040 Checksum, with LOADER_CHECKSUM_EN: words 00001, 00002 then trailer 00003 -> RUN and done.
REQ-041 Checksum mismatch: trailer 00000 -> ERROR, err=1, cpu_reset stays 1, and a following load_start clears err.
REQ-042 Reset: reset asserted mid-LOAD -> state IDLE, imem_we=0 and in_ready=0 in the next cycle.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to verify an XOR trailer word after the data words.
module imem_boot_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_ERROR, S_RUN} state_t;
   localparam state_t S_DATA_END = S_CHECK;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN} state_t;
   localparam state_t S_DATA_END = S_RUN;
`endif

   state_t            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d, len_q, len_d, count_inc;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] xor_q, xor_d;
   logic              err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      len_d       = len_q;
      count_inc   = count_q + 1'b1;
      in_ready    = 1'b0;
      imem_we     = 1'b0;
      imem_addr   = count_q[ADDR_W-1:0];
      imem_wdata  = in_data;
`ifdef LOADER_CHECKSUM_EN
      xor_d       = xor_q;
`endif
      // A zero-length load has nothing to accept, and reset/restart block the handshake.
      if (!reset && !load_start) begin
         if (state_q == S_LOAD && len_q != '0) in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (state_q == S_CHECK) in_ready = 1'b1;
`endif
      end
      if (load_start) begin
         state_d = S_LOAD;
         count_d = '0;
         len_d   = (load_len > DEPTH) ? DEPTH : load_len;
`ifdef LOADER_CHECKSUM_EN
         xor_d   = '0;
`endif
      end else begin
         case (state_q)
            S_LOAD: begin
               if (len_q == '0) begin
                  state_d = S_DATA_END;
               end else if (in_ready && in_valid) begin
                  imem_we = 1'b1;
                  count_d = count_inc;
`ifdef LOADER_CHECKSUM_EN
                  xor_d   = xor_q ^ in_data;
`endif
                  if (count_inc == len_q) state_d = S_DATA_END;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (in_ready && in_valid) state_d = (in_data == xor_q) ? S_RUN : S_ERROR;
            end
`endif
            default: ;
         endcase
      end
      cpu_reset_d = (state_d != S_RUN);
      done_d      = (state_d == S_RUN) && (state_q != S_RUN);
`ifdef LOADER_CHECKSUM_EN
      busy_d      = (state_d == S_LOAD) || (state_d == S_CHECK);
      err_d       = (state_d == S_ERROR);
`else
      busy_d      = (state_d == S_LOAD);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         len_q       <= '0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         len_q       <= len_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
         err_q       <= err_d;
`endif
      end
   end

   assign cpu_reset = cpu_reset_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a transaction-level reference model.
module tb_imem_boot_loader;
   localparam int AW = 10;
   localparam int DW = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, load_start, in_valid;
   logic [AW:0]   load_len;
   logic [DW-1:0] in_data;
   logic          in_ready, imem_we, cpu_reset, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;

   imem_boot_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .busy(busy), .done(done), .err(err)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: 0 idle, 1 loading, 2 awaiting trailer, 3 error, 4 running
   int            m_mode, m_len, m_cnt;
   logic [DW-1:0] m_xor;
   bit            m_done;

   logic          s_ready, s_we, s_cpu, s_busy, s_done, s_err;
   logic [AW-1:0] s_addr;
   int            nwrites, last_addr;
   int            wq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input bit r, input bit ls, input int len, input bit v, input logic [DW-1:0] d);
      bit e_ready, e_we;
      int lim;
      reset = r; load_start = ls; load_len = len[AW:0]; in_valid = v; in_data = d;
      @(negedge clk);
      e_ready = !r && !ls && ((m_mode == 1 && m_cnt < m_len) || m_mode == 2);
      e_we    = e_ready && v && (m_mode == 1);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("imem_we", 32'(imem_we), 32'(e_we));
      if (e_we) begin
         chk("imem_addr", 32'(imem_addr), 32'(m_cnt));
         chk("imem_wdata", 32'(imem_wdata), 32'(d));
      end
      chk("cpu_reset", 32'(cpu_reset), 32'(m_mode != 4));
      chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_mode == 3));
      s_ready = in_ready; s_we = imem_we; s_addr = imem_addr; s_cpu = cpu_reset;
      s_busy = busy; s_done = done; s_err = err;
      if (imem_we === 1'b1) begin
         nwrites++;
         last_addr = int'(imem_addr);
         wq.push_back(int'(imem_addr));
      end
      @(posedge clk);
      if (r) begin
         m_mode = 0; m_len = 0; m_cnt = 0; m_xor = '0; m_done = 0;
      end else if (ls) begin
         lim = (len > (1 << AW)) ? (1 << AW) : len;
         m_mode = 1; m_len = lim; m_cnt = 0; m_xor = '0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_mode == 1) begin
            if (e_ready && v) begin
               m_cnt++;
               m_xor = m_xor ^ d;
            end
            if (m_cnt >= m_len) begin
`ifdef LOADER_CHECKSUM_EN
               m_mode = 2;
`else
               m_mode = 4;
               m_done = 1;
`endif
            end
         end else if (m_mode == 2 && e_ready && v) begin
            if (d == m_xor) begin
               m_mode = 4;
               m_done = 1;
            end else begin
               m_mode = 3;
            end
         end
      end
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [31:0] r;
      r = $urandom;
      return r[DW-1:0];
   endfunction

   task automatic trailer();
`ifdef LOADER_CHECKSUM_EN
      cyc(0, 0, 0, 1, m_xor);
`endif
   endtask

   typedef struct {
      bit            ls;
      int            len;
      bit            v;
      logic [DW-1:0] d;
      bit            e_ready;
      bit            e_we;
      int            e_addr;
      bit            e_cpu;
      bit            e_done;
   } vec_t;

   vec_t          tbl[11];
   logic [DW-1:0] prog[7];

   initial begin
      prog = '{18'h08004, 18'h24000, 18'h20400, 18'h04840, 18'h24801, 18'h0cc81, 18'h24c00};
      tbl[0] = '{1, 7, 0, '0, 0, 0, 0, 1, 0};
      for (int i = 1; i <= 7; i++) tbl[i] = '{0, 0, 1, prog[i-1], 1, 1, i - 1, 1, 0};
`ifdef LOADER_CHECKSUM_EN
      tbl[8]  = '{0, 0, 1, 18'h044c4, 1, 0, 0, 1, 0};
      tbl[9]  = '{0, 0, 0, '0, 0, 0, 0, 0, 1};
      tbl[10] = '{0, 0, 0, '0, 0, 0, 0, 0, 0};
`else
      tbl[8]  = '{0, 0, 0, '0, 0, 0, 0, 0, 1};
      tbl[9]  = '{0, 0, 0, '0, 0, 0, 0, 0, 0};
      tbl[10] = '{0, 0, 1, 18'h3ffff, 0, 0, 0, 0, 0};
`endif

      reset = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
      m_mode = 0; m_len = 0; m_cnt = 0; m_xor = '0; m_done = 0;
      nwrites = 0; last_addr = -1;
      @(posedge clk);
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 1, 18'h12345);
      chk("reset_cpu", 32'(s_cpu), 32'd1);
      chk("reset_we", 32'(s_we), 32'd0);

      // Seven-word program with in_valid held high
      for (int i = 0; i < 11; i++) begin
         cyc(0, tbl[i].ls, tbl[i].len, tbl[i].v, tbl[i].d);
         chk("tbl_ready", 32'(s_ready), 32'(tbl[i].e_ready));
         chk("tbl_we", 32'(s_we), 32'(tbl[i].e_we));
         if (tbl[i].e_we) chk("tbl_addr", 32'(s_addr), 32'(tbl[i].e_addr));
         chk("tbl_cpu", 32'(s_cpu), 32'(tbl[i].e_cpu));
         chk("tbl_done", 32'(s_done), 32'(tbl[i].e_done));
      end

      // Backpressure: valid toggling
      cyc(0, 1, 3, 0, '0);
      nwrites = 0; wq.delete();
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, (i % 2) == 0, rnd_word());
      chk("bp_writes", 32'(nwrites), 32'd3);
      if (wq.size() == 3)
         for (int i = 0; i < 3; i++) chk("bp_addr", 32'(wq[i]), 32'(i));
      trailer();
      cyc(0, 0, 0, 0, '0);
      chk("bp_run", 32'(s_cpu), 32'd0);

      // Restart from RUN, then again mid-load
      cyc(0, 1, 5, 0, '0);
      cyc(0, 0, 0, 0, '0);
      chk("rs_cpu", 32'(s_cpu), 32'd1);
      cyc(0, 0, 0, 1, rnd_word());
      cyc(0, 0, 0, 1, rnd_word());
      cyc(0, 1, 5, 1, rnd_word());
      chk("rs_nowrite", 32'(s_we), 32'd0);
      cyc(0, 0, 0, 1, rnd_word());
      chk("rs_we", 32'(s_we), 32'd1);
      chk("rs_addr0", 32'(s_addr), 32'd0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, rnd_word());
      trailer();
      cyc(0, 0, 0, 0, '0);
      chk("rs_run", 32'(s_cpu), 32'd0);

      // Zero-length load
      cyc(0, 1, 0, 0, '0);
      nwrites = 0;
      cyc(0, 0, 0, 1, rnd_word());
      chk("z_nowrite", 32'(s_we), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      cyc(0, 0, 0, 1, '0);
      chk("z_check", 32'(s_busy), 32'd1);
`endif
      cyc(0, 0, 0, 0, '0);
      chk("z_run", 32'(s_cpu), 32'd0);
      chk("z_done", 32'(s_done), 32'd1);
      chk("z_writes", 32'(nwrites), 32'd0);

      // Oversize length clamps to the memory depth
      cyc(0, 1, 1500, 0, '0);
      nwrites = 0;
      for (int i = 0; i < (1 << AW); i++) cyc(0, 0, 0, 1, rnd_word());
      chk("big_writes", 32'(nwrites), 32'(1 << AW));
      chk("big_last", 32'(last_addr), 32'((1 << AW) - 1));
      cyc(0, 0, 0, 1, rnd_word());
      chk("big_stop", 32'(s_we), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      cyc(0, 1, 2, 0, '0);
      cyc(0, 0, 0, 1, 18'h00001);
      cyc(0, 0, 0, 1, 18'h00002);
      cyc(0, 0, 0, 1, 18'h00003);
      cyc(0, 0, 0, 0, '0);
      chk("ck_done", 32'(s_done), 32'd1);
      chk("ck_cpu", 32'(s_cpu), 32'd0);
      cyc(0, 1, 2, 0, '0);
      cyc(0, 0, 0, 1, 18'h00001);
      cyc(0, 0, 0, 1, 18'h00002);
      cyc(0, 0, 0, 1, 18'h00000);
      cyc(0, 0, 0, 1, 18'h00003);
      chk("ck_err", 32'(s_err), 32'd1);
      chk("ck_err_cpu", 32'(s_cpu), 32'd1);
      chk("ck_err_ready", 32'(s_ready), 32'd0);
      cyc(0, 1, 2, 0, '0);
      cyc(0, 0, 0, 0, '0);
      chk("ck_err_clr", 32'(s_err), 32'd0);
`endif

      // Reset in the middle of a load
      cyc(0, 1, 5, 0, '0);
      cyc(0, 0, 0, 1, rnd_word());
      cyc(0, 0, 0, 1, rnd_word());
      cyc(1, 1, 5, 1, rnd_word());
      chk("rst_we_same", 32'(s_we), 32'd0);
      cyc(0, 0, 0, 1, rnd_word());
      chk("rst_busy", 32'(s_busy), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_we", 32'(s_we), 32'd0);
      chk("rst_cpu", 32'(s_cpu), 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit            r, ls, v;
         int            len;
         logic [DW-1:0] d;
         r   = ($urandom_range(0, 199) == 0);
         ls  = ($urandom_range(0, 29) == 0);
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 1100))
                                           : int'($urandom_range(0, 12));
         v   = ($urandom_range(0, 3) != 0);
         d   = (m_mode == 2 && $urandom_range(0, 1) == 1) ? m_xor : rnd_word();
         cyc(r, ls, len, v, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
